imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the decode stage.
- Accepts a 32-bit instruction word, a 3-bit format select and a sideband tag (PC) over a valid/ready handshake.
- Returns the sign- or zero-extended immediate at XLEN width, one cycle later.
- A 2-entry output plus skid register gives full throughput under downstream stalls; supports flush on branch mispredict.

Parameters:
XLEN, 32, immediate output width; legal values 32 or 64.
TAG_W, 32, width of sideband tag carried alongside each immediate.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  instruction/immsrc/tag valid
in_ready  output  1  block can accept input this cycle
instr  input  32  instruction word; bits [6:0] ignored
immsrc  input  3  format select (encoding below)
in_tag  input  TAG_W  sideband tag
out_valid  output  1  immediate valid
out_ready  input  1  consumer accepts immediate
out_imm  output  XLEN  extended immediate
out_tag  output  TAG_W  tag matching out_imm
flush  input  1  discard all held and incoming entries

Behaviour:
- Clock and reset: one clock. reset_n is asynchronous and active-low.
  - While reset_n=0: out_valid=0, out_imm=0, out_tag=0, skid valid=0.
  - in_ready=1 from the first cycle after reset release.
- Formats, with S = instr[31] replicated to XLEN:
  - 000 I: S, instr[31:20].
  - 001 S: S, instr[31:25], instr[11:7].
  - 010 B: S, instr[7], instr[30:25], instr[11:8], 0.
  - 011 J: S, instr[19:12], instr[20], instr[30:21], 0.
  - 100 U: instr[31:12] followed by 12 zeros, then sign-extended from bit 31 to XLEN (XLEN=64 gives upper 32 bits = instr[31]).
  - 101 Z (CSR zimm): zero-extend instr[19:15].
  - 110 SH (shift amount): zero-extend instr[25:20] if XLEN=64, else instr[24:20].
  - 111: undefined; see Optional Feature.
- Handshake: a transfer occurs on a rising edge where valid && ready. Payload must be held stable while valid && !ready.
- Storage: output register (OR) and skid register (SK). in_ready = !SK.valid, registered and glitch-free.
- Edge update (flush=0):
  - Input accepted and (OR empty or out_ready): computed immediate goes to OR.
  - Else if input accepted: it goes to SK.
  - OR empty or consumed, and SK valid: SK moves to OR. This has priority over new input; the new input then lands in SK.
- Latency and throughput: 1 cycle from acceptance to out_valid with an empty pipe; one result per cycle sustained with out_ready=1.
- Ordering: results leave in strict acceptance order; no drops or duplicates.
- Full condition:
  - OR and SK both valid: in_ready=0, in_valid ignored.
  - The first cycle out_ready=1 drains OR, SK→OR, and in_ready=1 the following cycle.
- Flush:
  - At the next edge, OR.valid=0 and SK.valid=0.
  - An input presented in the flush cycle is discarded even if in_ready=1.
  - out_imm/out_tag values after flush are don't-care.
  - Simultaneous flush and out_ready: the consumer's transfer that cycle still counts; the entry behind it is dropped.
- Reset mid-operation: immediately clears all valid state; in-flight entries are lost.
- Data path: out_imm/out_tag update only when OR loads; they are stable while out_valid && !out_ready.

Optional Feature:
- Macro: IMM_ILLEGAL_CHK_EN.
- Defined:
  - Adds output port out_err (1 bit, reset 0), aligned with out_imm through OR/SK.
  - immsrc=111 gives out_err=1 and out_imm=0. Any other code gives out_err=0.
- Undefined:
  - No out_err port; immsrc=111 gives out_imm=0.
  - The entry otherwise flows normally in both cases.

Test Plan:
- Reset and simple I-type: XLEN=32; release reset_n; instr=0xFFF00093, immsrc=000, tag=0x100, out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF, out_tag=0x100; in_ready=1 throughout.
- Format sweep at XLEN=64:
  - B 0xFE000EE3 → 0xFFFFFFFFFFFFFFFC.
  - U 0x123450B7 → 0x0000000012345000.
  - Z with instr[19:15]=11111 → 0x1F.
  - SH with instr[25:20]=6'h3F → 0x3F.
- Backpressure: out_ready=0 while issuing 3 back-to-back inputs (tags 1,2,3) → tags 1,2 held, in_ready=0 after the 2nd; raise out_ready → outputs 1,2,3 in consecutive cycles, no loss.
- Flush: OR and SK full plus in_valid=1 with flush=1 → next cycle out_valid=0, in_ready=1; the discarded input never appears.
- Async reset mid-stream: drop reset_n between edges while out_valid=1 → out_valid=0 immediately, without waiting for a clock edge.
- Illegal code: immsrc=111 → out_imm=0; with IMM_ILLEGAL_CHK_EN, out_err=1 only on that entry.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Immediate generator with one-entry output register plus skid register (IMM_ILLEGAL_CHK_EN adds out_err).
// Latency: 1 cycle from input acceptance to out_valid; sustains one result per cycle.
// Backpressure: in_ready = !skid valid, so one extra entry is absorbed when out_ready drops.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
`ifdef IMM_ILLEGAL_CHK_EN
  output logic             out_err,
`endif
  input  logic             flush
);

  typedef struct packed {
`ifdef IMM_ILLEGAL_CHK_EN
    logic             err;
`endif
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t        nxt;
  ent_t        or_q;
  ent_t        sk_q;
  logic        or_vld;
  logic        sk_vld;
  logic        accept;
  logic        or_free;
  logic [31:0] base;
  logic        sext;
  logic        illegal;
  logic        unused_opcode;

  // Opcode bits never contribute to any immediate format.
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    base    = '0;
    sext    = 1'b0;
    illegal = 1'b0;
    case (immsrc)
      3'b000: begin base = {{20{instr[31]}}, instr[31:20]}; sext = 1'b1; end
      3'b001: begin base = {{20{instr[31]}}, instr[31:25], instr[11:7]}; sext = 1'b1; end
      3'b010: begin
        base = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        sext = 1'b1;
      end
      3'b011: begin
        base = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        sext = 1'b1;
      end
      3'b100: begin base = {instr[31:12], 12'b0}; sext = 1'b1; end
      3'b101: base = {27'b0, instr[19:15]};
      3'b110: base = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    nxt     = '0;
    nxt.tag = in_tag;
    nxt.imm = sext ? XLEN'($signed(base)) : XLEN'(base);
`ifdef IMM_ILLEGAL_CHK_EN
    nxt.err = illegal;
`endif
  end

  assign in_ready = !sk_vld;
  assign accept   = in_valid && in_ready;
  assign or_free  = !or_vld || out_ready;

  // Skid drains into OR ahead of new input; a new input then lands in SK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      or_vld <= 1'b0;
      sk_vld <= 1'b0;
      or_q   <= '0;
      sk_q   <= '0;
    end else if (flush) begin
      or_vld <= 1'b0;
      sk_vld <= 1'b0;
    end else if (or_free) begin
      if (sk_vld) begin
        or_q   <= sk_q;
        or_vld <= 1'b1;
        sk_vld <= accept;
        if (accept) sk_q <= nxt;
      end else if (accept) begin
        or_q   <= nxt;
        or_vld <= 1'b1;
      end else begin
        or_vld <= 1'b0;
      end
    end else if (accept) begin
      sk_q   <= nxt;
      sk_vld <= 1'b1;
    end
  end

  assign out_valid = or_vld;
  assign out_imm   = or_q.imm;
  assign out_tag   = or_q.tag;
`ifdef IMM_ILLEGAL_CHK_EN
  assign out_err   = or_q.err;
`endif

  // Illegal code already yields a zero immediate; keep the flag referenced in every build.
  logic unused_illegal;
  assign unused_illegal = illegal ^ unused_opcode;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed plus random stimulus against a queue-based reference of imm_gen_pipe at XLEN=64.
module tb_imm_gen_pipe;
  localparam int XLEN  = 64;
  localparam int TAG_W = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [2:0]       immsrc;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             flush;
`ifdef IMM_ILLEGAL_CHK_EN
  logic             out_err;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] imm;
    logic [31:0] tag;
    logic        err;
  } exp_t;

  exp_t q[$];

  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .immsrc    (immsrc),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_tag   (out_tag),
`ifdef IMM_ILLEGAL_CHK_EN
    .out_err   (out_err),
`endif
    .flush     (flush)
  );

  always #5 clk = ~clk;

  // Immediate value computed as a signed integer from the field layout of each format.
  function automatic exp_t model(logic [31:0] i, logic [2:0] s, logic [31:0] t);
    longint v;
    exp_t   e;
    v     = 0;
    e.err = 1'b0;
    e.tag = t;
    case (s)
      3'd0: begin v = i[31:20]; if (i[31]) v = v - 4096; end
      3'd1: begin v = {i[31:25], i[11:7]}; if (i[31]) v = v - 4096; end
      3'd2: begin v = {i[31], i[7], i[30:25], i[11:8], 1'b0}; if (i[31]) v = v - 8192; end
      3'd3: begin v = {i[31], i[19:12], i[20], i[30:21], 1'b0}; if (i[31]) v = v - 2097152; end
      3'd4: begin v = i[31:12]; v = v * 4096; if (i[31]) v = v - 64'sd4294967296; end
      3'd5: v = i[19:15];
      3'd6: v = (XLEN == 64) ? i[25:20] : i[24:20];
      default: begin v = 0; e.err = 1'b1; end
    endcase
    e.imm = (XLEN == 64) ? 64'(v) : (64'(v) & 64'hFFFF_FFFF);
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_state();
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_imm", out_imm, q[0].imm);
      chk("out_tag", 64'(out_tag), 64'(q[0].tag));
`ifdef IMM_ILLEGAL_CHK_EN
      chk("out_err", 64'(out_err), 64'(q[0].err));
`endif
    end
  endtask

  // One clock: update the reference on the edge, then check at the falling edge.
  task automatic step(output bit acc);
    bit pop;
    acc = in_valid && (q.size() < 2) && !flush && reset_n;
    pop = out_ready && (q.size() != 0);
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(model(instr, immsrc, in_tag));
    end
    @(negedge clk);
    check_state();
  endtask

  task automatic send_one(logic [31:0] i, logic [2:0] s, logic [31:0] t,
                          logic [63:0] exp, logic experr);
    bit a;
    in_valid = 1'b1; instr = i; immsrc = s; in_tag = t; out_ready = 1'b1; flush = 1'b0;
    step(a);
    in_valid = 1'b0;
    chk("dir_vld", 64'(out_valid), 64'd1);
    chk("dir_imm", out_imm, exp);
    chk("dir_tag", 64'(out_tag), 64'(t));
`ifdef IMM_ILLEGAL_CHK_EN
    chk("dir_err", 64'(out_err), 64'(experr));
`else
    if (experr) chk("dir_ill_imm", out_imm, 64'd0);
`endif
    step(a);
  endtask

  initial begin
    bit acc;
    reset_n = 1'b0; in_valid = 1'b0; instr = '0; immsrc = '0; in_tag = '0;
    out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_imm", out_imm, 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    reset_n = 1'b1;
    #1 check_state();
    @(negedge clk);

    send_one(32'hFFF00093, 3'b000, 32'h100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_one(32'hFE000EE3, 3'b010, 32'h101, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send_one(32'h123450B7, 3'b100, 32'h102, 64'h0000_0000_1234_5000, 1'b0);
    send_one(32'h000F8000, 3'b101, 32'h103, 64'h1F, 1'b0);
    send_one(32'h03F00000, 3'b110, 32'h104, 64'h3F, 1'b0);
    send_one(32'hFFFFFFFF, 3'b111, 32'h105, 64'h0, 1'b1);
    send_one(32'h80000037, 3'b100, 32'h106, 64'hFFFF_FFFF_8000_0000, 1'b0);

    // Backpressure: two held, third refused until the drain starts.
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00100093; immsrc = 3'b000;
    in_tag = 32'd1; step(acc);
    in_tag = 32'd2; step(acc);
    chk("bp_full_rdy", 64'(in_ready), 64'd0);
    chk("bp_head1", 64'(out_tag), 64'd1);
    in_tag = 32'd3; step(acc);
    chk("bp_hold1", 64'(out_tag), 64'd1);
    out_ready = 1'b1; step(acc);
    chk("bp_head2", 64'(out_tag), 64'd2);
    chk("bp_rdy_back", 64'(in_ready), 64'd1);
    step(acc);
    chk("bp_head3", 64'(out_tag), 64'd3);
    in_valid = 1'b0; step(acc);
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush with both registers full and an input presented.
    out_ready = 1'b0; in_valid = 1'b1;
    in_tag = 32'h11; step(acc);
    in_tag = 32'h12; step(acc);
    in_tag = 32'h77; flush = 1'b1; step(acc);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_rdy", 64'(in_ready), 64'd1);
    in_tag = 32'h78; step(acc);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(acc); step(acc);
    chk("fl_gone", 64'(out_valid), 64'd0);

    // Asynchronous reset between edges while a result is held.
    in_valid = 1'b1; in_tag = 32'h55; out_ready = 1'b0; step(acc);
    in_valid = 1'b0;
    chk("ar_pre", 64'(out_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_imm", out_imm, 64'd0);
    chk("ar_tag", 64'(out_tag), 64'd0);
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    #1 check_state();
    @(negedge clk);

    // Random traffic; a refused payload is held until accepted or flushed.
    acc = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!(in_valid && !acc && !flush)) begin
        in_valid = ($urandom_range(0, 2) != 0);
        instr    = $urandom;
        immsrc   = 3'($urandom_range(0, 7));
        in_tag   = $urandom;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      step(acc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
